// File: rtl/qbuf_pingpong_pkg.sv
// qbuf_pingpong_pkg: shared JPEG types for the quantizer and its ping-pong output buffer.
package qbuf_pingpong_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} qbuf_state_t;
    localparam int QBUF_WORDS = 32;
    typedef struct packed {
        logic [15:0] coef_lo;
        logic [15:0] coef_hi;
    } coef_pair_t;
endpackage

// File: rtl/qbuf_ram.sv
// qbuf_ram: simple dual-port RAM with synchronous, resettable read register.
module qbuf_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= rst ? '0 : mem[raddr];
    end
endmodule

// File: rtl/qbuf_pingpong.sv
// qbuf_pingpong: two-bank block buffer between the JPEG quantizer and the CPU.
// Optional level interrupt irq_o is generated when QBUF_IRQ_EN is defined.
module qbuf_pingpong
    import qbuf_pingpong_pkg::*;
#(
    parameter int WORDS = QBUF_WORDS,
    parameter int AW    = 5
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wr_valid_i,
    input  logic [31:0]   wr_data_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    output logic          blk_rdy_o,
    input  logic          rd_done_i,
    output logic [AW:0]   fill_o,
    output logic          irq_o
);
    qbuf_state_t   state [2];
    logic          wbank, rbank;
    logic [AW-1:0] wcnt;
    logic          xfer, last, done_ok;
    coef_pair_t    wword;
    assign wword      = wr_data_i;
    assign wr_ready_o = !wb_rst_i && state[wbank] != FULL;
    assign xfer       = wr_valid_i && wr_ready_o;
    assign last       = xfer && wcnt == AW'(WORDS - 1);
    assign blk_rdy_o  = state[rbank] == FULL;
    assign done_ok    = rd_done_i && blk_rdy_o;
    assign fill_o     = state[wbank] == FULL ? (AW+1)'(WORDS) : {1'b0, wcnt};
    // A write and an accepted rd_done can only hit the same bank when both are FULL, where no write occurs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            wcnt     <= '0;
        end else begin
            if (xfer) begin
                wcnt         <= last ? '0 : wcnt + 1'b1;
                state[wbank] <= last ? FULL : FILLING;
                if (last) wbank <= ~wbank;
            end
            if (done_ok) begin
                state[rbank] <= EMPTY;
                rbank        <= ~rbank;
            end
        end
    end
    qbuf_ram #(.DEPTH(2 * WORDS), .AW(AW + 1), .DW(32)) u_ram (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .we    (xfer),
        .waddr ({wbank, wcnt}),
        .wdata (wword),
        .raddr ({rbank, rd_addr_i}),
        .rdata (rd_data_o)
    );
`ifdef QBUF_IRQ_EN
    logic irq_q;
    // Clearing drops irq for one cycle; a still-FULL bank re-raises it through blk_rdy_o.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= done_ok ? 1'b0 : (irq_q || last || blk_rdy_o);
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_qbuf_pingpong.sv
// tb_qbuf_pingpong: randomized self-checking bench; model tracks blocks as counts of ready blocks.
module tb_qbuf_pingpong;
`ifdef QBUF_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        blk_rdy;
    logic        rd_done = 1'b0;
    logic [5:0]  fill;
    logic        irq;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_mem [64];
    int          m_nfull = 0;
    int          m_cnt = 0;
    bit          m_wb = 0, m_rb = 0, m_irq = 0;
    logic [31:0] m_rd = '0;

    qbuf_pingpong dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .blk_rdy_o(blk_rdy),
        .rd_done_i(rd_done), .fill_o(fill), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        bit acc, dok;
        acc = wr_valid && !rst && m_nfull != 2;
        dok = rd_done && m_nfull > 0;
        @(posedge clk);
        if (rst) begin
            m_nfull = 0; m_cnt = 0; m_wb = 0; m_rb = 0; m_irq = 0; m_rd = '0;
        end else begin
            m_rd = m_mem[{m_rb, rd_addr}];
            if (acc) begin
                m_mem[{m_wb, 5'(m_cnt)}] = wr_data;
                m_cnt++;
                if (m_cnt == 32) begin m_cnt = 0; m_nfull++; m_wb = !m_wb; end
            end
            if (dok) begin m_nfull--; m_rb = !m_rb; end
            m_irq = !dok && m_nfull > 0;
        end
        #1;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1; wr_data = $urandom; tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", wr_ready); end
        checks++; if (rd_data !== 32'h0 || blk_rdy !== 1'b0 || fill !== 6'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: rd_data=%h blk=%b fill=%0d irq=%b exp 0", rd_data, blk_rdy, fill, irq);
        end
        rst = 1'b0; #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", wr_ready); end
    endtask

    task automatic test_first_block();
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_data = {16'(2 * i + 1), 16'(2 * i + 2)};
            checks++; if (wr_ready !== 1'b1 || fill !== 6'(i)) begin
                errors++; $display("FAIL first_fill[%0d]: ready=%b fill=%0d exp 1/%0d", i, wr_ready, fill, i);
            end
            tick();
            checks++; if (blk_rdy !== (i == 31)) begin errors++; $display("FAIL first_blk[%0d]: got %b exp %b", i, blk_rdy, i == 31); end
        end
        wr_valid = 1'b0;
        checks++; if (fill !== 6'd0) begin errors++; $display("FAIL first_fill_wrap: got %0d exp 0", fill); end
        checks++; if (irq !== IRQ_EN) begin errors++; $display("FAIL first_irq: got %b exp %b", irq, IRQ_EN); end
        rd_addr = 5'd0; tick();
        checks++; if (rd_data !== 32'h00010002) begin errors++; $display("FAIL read_addr0: got %h exp 00010002", rd_data); end
        rd_addr = 5'd31; tick();
        checks++; if (rd_data !== 32'h003F0040) begin errors++; $display("FAIL read_addr31: got %h exp 003f0040", rd_data); end
    endtask

    task automatic test_both_full();
        logic [31:0] w65;
        feed(32);
        checks++; if (wr_ready !== 1'b0 || fill !== 6'd32 || blk_rdy !== 1'b1) begin
            errors++; $display("FAIL both_full: ready=%b fill=%0d blk=%b exp 0/32/1", wr_ready, fill, blk_rdy);
        end
        w65 = $urandom; wr_valid = 1'b1; wr_data = w65;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wr_ready !== 1'b0 || fill !== 6'd32) begin
                errors++; $display("FAIL stall[%0d]: ready=%b fill=%0d exp 0/32", i, wr_ready, fill);
            end
        end
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        checks++; if (wr_ready !== 1'b1 || fill !== 6'd0) begin
            errors++; $display("FAIL free_ready: ready=%b fill=%0d exp 1/0", wr_ready, fill);
        end
        tick(); wr_valid = 1'b0;
        checks++; if (fill !== 6'd1) begin errors++; $display("FAIL w65_fill: got %0d exp 1", fill); end
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        rd_addr = 5'd0; tick();
        checks++; if (rd_data !== w65 || rd_data !== m_rd) begin
            errors++; $display("FAIL w65_bank0: got %h exp %h", rd_data, w65);
        end
    endtask

    task automatic test_same_edge();
        feed(31);
        feed(31);
        wr_valid = 1'b1; wr_data = $urandom; rd_done = 1'b1;
        tick();
        wr_valid = 1'b0; rd_done = 1'b0;
        checks++; if (blk_rdy !== 1'b1 || fill !== 6'd0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL same_edge: blk=%b fill=%0d ready=%b exp 1/0/1", blk_rdy, fill, wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = (i == 3) ? 5'd31 : 5'($urandom); tick();
            checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL same_edge_read[%0d]: got %h exp %h", rd_addr, rd_data, m_rd); end
        end
        rd_done = 1'b1; tick(); rd_done = 1'b0;
    endtask

    task automatic test_ignored_done();
        logic [5:0] f0;
        feed(3);
        f0 = fill;
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        checks++; if (blk_rdy !== 1'b0 || fill !== f0 || irq !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL ignored_done: blk=%b fill=%0d irq=%b ready=%b exp 0/%0d/0/1", blk_rdy, fill, irq, wr_ready, f0);
        end
        rd_addr = 5'd1; tick();
        checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL ignored_done_read: got %h exp %h", rd_data, m_rd); end
    endtask

    task automatic test_reset_mid();
        feed(10);
        rst = 1'b1; tick();
        checks++; if (wr_ready !== 1'b0 || rd_data !== 32'h0 || blk_rdy !== 1'b0 || fill !== 6'd0 || irq !== 1'b0) begin
            errors++; $display("FAIL mid_reset: ready=%b rd=%h blk=%b fill=%0d irq=%b exp all 0", wr_ready, rd_data, blk_rdy, fill, irq);
        end
        rst = 1'b0;
        feed(32);
        checks++; if (blk_rdy !== 1'b1 || fill !== 6'd0) begin
            errors++; $display("FAIL mid_reset_block: blk=%b fill=%0d exp 1/0", blk_rdy, fill);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a); tick();
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL mid_reset_read[%0d]: got %h exp %h", a, rd_data, m_mem[a]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 9) < 7);
            wr_data  = $urandom;
            rd_done  = ($urandom_range(0, 9) == 0);
            rd_addr  = 5'($urandom);
            tick();
            checks++; if (wr_ready !== (m_nfull != 2) || blk_rdy !== (m_nfull > 0) ||
                          fill !== 6'(m_nfull == 2 ? 32 : m_cnt) || irq !== (IRQ_EN && m_irq) || rd_data !== m_rd) begin
                errors++;
                $display("FAIL random[%0d]: ready=%b blk=%b fill=%0d irq=%b rd=%h exp %b/%b/%0d/%b/%h", i, wr_ready, blk_rdy, fill, irq, rd_data,
                         m_nfull != 2, m_nfull > 0, m_nfull == 2 ? 32 : m_cnt, IRQ_EN && m_irq, m_rd);
            end
        end
        wr_valid = 1'b0; rd_done = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_first_block();
        test_both_full();
        test_same_edge();
        test_ignored_done();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qbuf_pingpong.md
# qbuf_pingpong

Two-bank ping-pong buffer directly downstream of the JPEG quantizer. Each cycle it can accept one 32-bit quantizer result word holding two packed 16-bit coefficients. It stores 32 words, one complete 8x8 block, per bank. While the quantizer fills one bank, the CPU/Wishbone side reads the other bank at random addresses.

## Interface
Parameters:
- WORDS, 32, words per block (8x8 coefficients / 2 per word); power of two
- AW, 5, word address width, log2(WORDS)

Ports:
- wb_clk_i  in  1  single clock; all logic rising-edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wr_valid_i  in  1  quantizer word valid
- wr_data_i  in  32  {coef_n[15:0], coef_n+1[15:0]}; stored verbatim
- wr_ready_o  out  1  write bank can accept a word
- rd_addr_i  in  AW  word address within the readable bank
- rd_data_o  out  32  registered read data
- blk_rdy_o  out  1  readable bank holds a full block
- rd_done_i  in  1  single-cycle pulse: CPU finished with the readable bank
- fill_o  out  AW+1  words accepted so far in the current write bank (0..WORDS)
- irq_o  out  1  block-ready interrupt (QBUF_IRQ_EN only; tied 0 otherwise)

## Operation
- Per-bank state, 2-bit enum: EMPTY, FILLING, FULL.
- Pointers, 1 bit each: wbank (bank being written) and rbank (bank being read).
- Write counter: wcnt, AW bits.
- Write transfer = wr_valid_i && wr_ready_o.
  - mem[wbank][wcnt] <= wr_data_i.
  - wcnt increments.
  - state[wbank] moves EMPTY->FILLING on the first word.
- Transfer with wcnt==WORDS-1:
  - state[wbank] -> FULL.
  - wcnt -> 0.
  - wbank toggles.
- wr_ready_o = !wb_rst_i && state[wbank]!=FULL.
- blk_rdy_o = state[rbank]==FULL, from registers.
- rd_data_o <= mem[rbank][rd_addr_i] every cycle, regardless of blk_rdy_o.
- rd_done_i while blk_rdy_o:
  - state[rbank] -> EMPTY.
  - rbank toggles.
- rd_done_i while !blk_rdy_o: ignored, with no state change.
- fill_o = wcnt while state[wbank]!=FULL; WORDS when both banks are FULL.
- Boundary conditions:
  - Both banks FULL: wr_ready_o=0 and the quantizer stalls. rd_done_i frees rbank. wr_ready_o rises the cycle after rd_done_i, never combinationally.
  - Block completes and rd_done_i arrives in the same cycle: both updates apply. They target different banks, except in the both-FULL case, where no write can occur.
  - wr_valid_i held high while wr_ready_o=0: data is not captured and the counter holds.
  - Reset mid-block: the partial block and both FULL blocks are discarded; memory contents are not cleared.

## Timing
- Reset values:
  - both banks EMPTY
  - wbank=rbank=0, wcnt=0
  - rd_data_o=0, blk_rdy_o=0, fill_o=0, irq_o=0
  - wr_ready_o=0 during reset, 1 the first cycle after
- Write-to-ready latency: the word accepted at edge N completes the block; blk_rdy_o is high after edge N.
- Read latency: 1 cycle. rd_addr_i presented before edge N gives rd_data_o valid after edge N.
- Sustained throughput: 1 word/cycle while a bank is free; a full block takes 32 cycles.
- Memory: inferred synchronous RAM, 2x32x32, one write port and one read port. The read address is {rbank, rd_addr_i}.

## Configuration
- QBUF_IRQ_EN defined:
  - irq_o is a level interrupt, set the cycle a bank becomes FULL.
  - irq_o is cleared by an accepted rd_done_i.
  - If another bank is already FULL when rd_done_i clears it, irq_o re-asserts the next cycle.
- QBUF_IRQ_EN undefined:
  - irq_o is constant 0 and no interrupt logic is generated.
  - The CPU polls blk_rdy_o.

## Structure
- Shared jpeg package holds:
  - bank state enum qbuf_state_t
  - constant QBUF_WORDS=32
  - the packed-coefficient word typedef, used by the quantizer as well
- One sub-module, qbuf_ram: 64x32 simple dual-port RAM with synchronous read. It keeps RAM inference isolated from the control FSM.

## Test plan
- Reset, then 32 words 0x00010002..0x003F0040 with wr_valid_i held high:
  - wr_ready_o stays 1.
  - blk_rdy_o rises after the 32nd edge.
  - fill_o is 0..31 then 0.
  - Reading addr 0 gives 0x00010002; addr 31 gives 0x003F0040.
- Fill both banks (64 words) without rd_done_i:
  - wr_ready_o=0 after word 64 and fill_o=32.
  - Word 65 is held and not stored.
  - After rd_done_i, wr_ready_o returns 1 the next cycle; word 65 lands at bank 0 addr 0.
- rd_done_i on the same edge that word 32 of the other bank is accepted: blk_rdy_o stays 1, rbank toggles, new data is readable.
- rd_done_i pulsed with blk_rdy_o=0: no change to pointers, states, or irq_o.
- Assert wb_rst_i after 10 words:
  - All outputs return to reset values.
  - The next 32 words form block 0 at bank 0 and read back correctly.
- With QBUF_IRQ_EN:
  - irq_o rises with blk_rdy_o, falls after rd_done_i, and re-rises if the second bank is FULL.
  - Without the macro, irq_o is 0 throughout.
